dff_mem_burst: RTL and testbench

Parametrised flip-flop memory with a burst-capable, handshaked command port; the next generation of the team's DFF scratch RAM. It replaces level-sampled read/write strobes with valid/ready transactions, adds configurable width and depth, and adds auto-incrementing bursts with wrap-around and a registered read pipeline with backpressure. It sits between a project-level control FSM or pin-decoder and its local scratch storage.

---
 rtl/dff_mem_burst_pkg.sv | 19 +
 rtl/dff_mem_burst_array.sv | 30 +++
 rtl/dff_mem_burst.sv | 191 +++++++++++++++++++
 tb/tb_dff_mem_burst.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_mem_burst_pkg.sv
// Shared types and helpers for the burst-capable DFF scratch RAM.
// Optional build macro: DFF_MEM_BURST_PARITY_EN (per-word even parity).
package dff_mem_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    // Widest data word the parity helper accepts; narrower words are zero-extended.
    localparam int PAR_MAX_W = 64;

    // Even-parity bit: makes the total number of ones (data + bit) even.
    function automatic logic calc_even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dff_mem_burst_array.sv
// Word storage for dff_mem_burst: one synchronous write port, one
// combinational read port. Contents are deliberately not reset.
// Optional build macro: DFF_MEM_BURST_PARITY_EN (STORE_W carries the parity bit).
module dff_mem_burst_array
    import dff_mem_burst_pkg::*;
#(
    parameter int STORE_W = 8,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH)
)(
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [STORE_W-1:0] wword,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [STORE_W-1:0] rword
);

    logic [STORE_W-1:0] mem_r [DEPTH];

    // Synchronous write port; addresses are always below DEPTH by construction.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wword;
        end
    end

    assign rword = mem_r[raddr];

endmodule

// File: rtl/dff_mem_burst.sv
// Parametrised DFF memory with a valid/ready burst command port, wrapping
// auto-increment addressing and a registered read stage with backpressure.
// Optional build macro: DFF_MEM_BURST_PARITY_EN (even parity per word,
// mismatch reported on rdata_perr; without it rdata_perr is constant 0).
module dff_mem_burst
    import dff_mem_burst_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              req_err,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              rdata_perr,
    output logic              busy
);

`ifdef DFF_MEM_BURST_PARITY_EN
    localparam int STORE_W = DATA_W + 1;
`else
    localparam int STORE_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [LEN_W-1:0]  CNT_ZERO  = {LEN_W{1'b0}};

    state_e              state_r;
    logic [ADDR_W-1:0]   ptr_r;
    logic [LEN_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                rdata_valid_r;
    logic                rdata_last_r;
    logic                rdata_perr_r;
    logic                req_err_r;
    logic                busy_r;

    logic                req_ready_s;
    logic                wdata_ready_s;
    logic                accept_s;
    logic                addr_bad_s;
    logic                wr_beat_s;
    logic                rd_issue_s;
    logic [ADDR_W-1:0]   ptr_next_s;
    logic [STORE_W-1:0]  wword_s;
    logic [STORE_W-1:0]  rword_s;
    logic [DATA_W-1:0]   rword_data_s;
    logic                rword_perr_s;

    // Handshake decode: commands only in IDLE once the output register can drain.
    always_comb begin
        req_ready_s   = (state_r == ST_IDLE) && (!rdata_valid_r || rdata_ready);
        wdata_ready_s = (state_r == ST_WRITE);
        accept_s      = req_valid && req_ready_s;
        addr_bad_s    = ({1'b0, req_addr} >= DEPTH_EXT);
        wr_beat_s     = wdata_ready_s && wdata_valid;
        rd_issue_s    = (state_r == ST_READ) && (!rdata_valid_r || rdata_ready);
        if (ptr_r == LAST_ADDR) begin
            ptr_next_s = {ADDR_W{1'b0}};
        end else begin
            ptr_next_s = ptr_r + ADDR_W'(1);
        end
    end

`ifdef DFF_MEM_BURST_PARITY_EN
    logic [PAR_MAX_W-1:0] par_wr_s;
    logic [PAR_MAX_W-1:0] par_rd_s;

    // Attach parity on write and recompute it on read to detect stored-bit flips.
    always_comb begin
        par_wr_s               = {PAR_MAX_W{1'b0}};
        par_wr_s[DATA_W-1:0]   = wdata;
        wword_s                = {calc_even_parity(par_wr_s), wdata};
        rword_data_s           = rword_s[DATA_W-1:0];
        par_rd_s               = {PAR_MAX_W{1'b0}};
        par_rd_s[DATA_W-1:0]   = rword_s[DATA_W-1:0];
        rword_perr_s           = calc_even_parity(par_rd_s) ^ rword_s[DATA_W];
    end
`else
    // Plain storage: the word is the data and no parity error can be raised.
    always_comb begin
        wword_s      = wdata;
        rword_data_s = rword_s;
        rword_perr_s = 1'b0;
    end
`endif

    // A beat presented on the reset edge must not reach the array.
    dff_mem_burst_array #(
        .STORE_W (STORE_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (wr_beat_s && !rst),
        .waddr (ptr_r),
        .wword (wword_s),
        .raddr (ptr_r),
        .rword (rword_s)
    );

    // Controller FSM plus registered read stage and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            ptr_r         <= {ADDR_W{1'b0}};
            cnt_r         <= CNT_ZERO;
            rdata_r       <= {DATA_W{1'b0}};
            rdata_valid_r <= 1'b0;
            rdata_last_r  <= 1'b0;
            rdata_perr_r  <= 1'b0;
            req_err_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            req_err_r <= 1'b0;

            if (rd_issue_s) begin
                rdata_r       <= rword_data_s;
                rdata_valid_r <= 1'b1;
                rdata_last_r  <= (cnt_r == CNT_ZERO);
                rdata_perr_r  <= rword_perr_s;
            end else if (rdata_ready) begin
                rdata_valid_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (addr_bad_s) begin
                            req_err_r <= 1'b1;
                        end else begin
                            ptr_r   <= req_addr;
                            cnt_r   <= req_len;
                            busy_r  <= 1'b1;
                            state_r <= req_we ? ST_WRITE : ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_beat_s) begin
                        if (cnt_r == CNT_ZERO) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r - LEN_W'(1);
                            ptr_r <= ptr_next_s;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_issue_s) begin
                        if (cnt_r == CNT_ZERO) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r - LEN_W'(1);
                            ptr_r <= ptr_next_s;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_s;
    assign wdata_ready = wdata_ready_s;
    assign req_err     = req_err_r;
    assign rdata_valid = rdata_valid_r;
    assign rdata       = rdata_r;
    assign rdata_last  = rdata_last_r;
    assign rdata_perr  = rdata_perr_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_dff_mem_burst.sv
// Scoreboard bench for dff_mem_burst (DEPTH 12 to exercise non-power-of-two
// wrap and out-of-range addresses). Reads push expected beats, computed from
// a plain array model with modulo addressing, into a queue popped by a monitor.
module tb_dff_mem_burst;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 12;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              req_err;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_last;
    logic              rdata_perr;
    logic              busy;

    typedef struct {
        int data;
        bit last;
    } beat_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    ref_mem [DEPTH];
    beat_t exp_q [$];
    beat_t mon_beat;
    int    wdat_q [$];
    bit    wv_full;
    int    rr_mode;
    bit    rr_pat [$];
    bit    prev_stall;
    logic [DATA_W-1:0] prev_data;

    dff_mem_burst #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_err     (req_err),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .rdata_perr  (rdata_perr),
        .busy        (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic void check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Consumer backpressure: pattern first, then always-ready or random.
    initial begin
        rdata_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rr_pat.size() > 0) rdata_ready = rr_pat.pop_front();
            else if (rr_mode == 1) rdata_ready = 1'($urandom_range(0, 1));
            else rdata_ready = 1'b1;
        end
    end

    // Monitor: pops expected beats on every read handshake; checks stall hold.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", rdata_valid, 1);
                check("stall_hold_data", rdata, prev_data);
            end
            if (rdata_valid && rdata_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    mon_beat = exp_q.pop_front();
                    check("rdata", rdata, mon_beat.data);
                    check("rdata_last", rdata_last, mon_beat.last);
                    check("rdata_perr", rdata_perr, 0);
                end
            end
            if (rdata_valid && !rdata_ready) check("req_ready_while_stalled", req_ready, 0);
            prev_stall = rdata_valid && !rdata_ready;
            prev_data  = rdata;
        end
    end

    task automatic wait_accept(input bit we, input int addr, input int len, output bit ok);
        int cyc;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = ADDR_W'(addr);
        req_len   = LEN_W'(len);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!req_ready && cyc < 300);
        ok = req_ready;
        if (!ok) begin
            check("req_ready_timeout", 0, 1);
            req_valid = 1'b0;
        end
    endtask

    task automatic send_cmd(input bit we, input int addr, input int len);
        int    cyc;
        int    beats;
        bit    ok;
        bit    timed;
        beat_t b;
        timed = (rr_mode == 0) && (rr_pat.size() == 0);
        wait_accept(we, addr, len, ok);
        if (!ok) return;
        if (!we && addr < DEPTH) begin
            for (int i = 0; i <= len; i++) begin
                b.data = ref_mem[(addr + i) % DEPTH];
                b.last = (i == len);
                exp_q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (addr >= DEPTH) begin
            check("req_err_pulse", req_err, 1);
            check("req_err_busy", busy, 0);
            @(posedge clk);
            #1;
            check("req_err_clear", req_err, 0);
            check("req_err_busy_after", busy, 0);
            return;
        end
        check("busy_after_accept", busy, 1);
        check("no_req_err", req_err, 0);
        if (we) begin
            check("wdata_ready_after_accept", wdata_ready, 1);
            beats = 0;
            cyc   = 0;
            while (beats <= len && cyc < 500) begin
                wdata_valid = wv_full ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                wdata = (wdat_q.size() > 0) ? DATA_W'(wdat_q[0]) : DATA_W'($urandom);
                @(negedge clk);
                if (wdata_valid && wdata_ready) begin
                    ref_mem[(addr + beats) % DEPTH] = int'(wdata);
                    if (wdat_q.size() > 0) void'(wdat_q.pop_front());
                    beats++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            wdata_valid = 1'b0;
            if (beats <= len) check("write_timeout", 0, 1);
            if (wv_full) check("write_cycles", cyc, len + 1);
            check("busy_after_write", busy, 0);
        end else begin
            check("rvalid_empty_at_accept", rdata_valid, 0);
            @(posedge clk);
            #1;
            check("rvalid_latency", rdata_valid, 1);
            cyc = 1;
            while (busy && cyc < 500) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check("busy_after_read", busy, 0);
            if (timed) check("read_cycles", cyc, len + 1);
        end
    endtask

    // Main stimulus sequence.
    initial begin
        bit ok;
        int cyc;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0;
        rr_mode = 0; wv_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_req_err", req_err, 0);
        check("rst_wdata_ready", wdata_ready, 0);
        check("rst_rdata_valid", rdata_valid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rdata_last", rdata_last, 0);
        check("rst_rdata_perr", rdata_perr, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;

        // Fill the whole memory so every later read has defined data.
        wv_full = 1'b1;
        send_cmd(1'b1, 0, DEPTH - 1);

        // Directed burst: A0..A3 at address 2, then read back.
        wdat_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        send_cmd(1'b1, 2, 3);
        send_cmd(1'b0, 2, 3);

        // Wrap across the last address.
        wdat_q = '{1, 2, 3, 4};
        send_cmd(1'b1, 10, 3);
        send_cmd(1'b0, 10, 3);
        check("wrap_model_0", ref_mem[0], 3);

        // Burst longer than DEPTH re-reads from the start.
        send_cmd(1'b0, 5, 15);

        // Stalled read burst.
        rr_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        send_cmd(1'b0, 4, 2);

        // Out-of-range addresses, then confirm memory untouched.
        send_cmd(1'b0, 13, 2);
        send_cmd(1'b1, 12, 0);
        send_cmd(1'b0, 0, DEPTH - 1);

        // Reset after two beats of a four-beat write.
        wait_accept(1'b1, 6, 3, ok);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata_valid = 1'b1;
            wdata = DATA_W'(8'h50 + i);
            @(posedge clk);
            ref_mem[6 + i] = 8'h50 + i;
            #1;
        end
        rst = 1'b1;
        wdata = 8'hEE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wdata_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_wdata_ready", wdata_ready, 0);
        check("abort_req_ready", req_ready, 1);
        send_cmd(1'b0, 4, 6);

        // Randomized mix with random backpressure and write gaps.
        wv_full = 1'b0;
        rr_mode = 1;
        for (int n = 0; n < 60; n++) begin
            send_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15));
        end

        cyc = 0;
        while (exp_q.size() > 0 && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
